// File: rtl/osc_seq_ctrl.sv
// Sequencer/configurator for one recursive sine oscillator: config handshake, load strobe,
// sample tick and zero-crossing-aligned changes. Define SOFT_STOP_EN for zero-crossing stops.
module osc_seq_ctrl #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             Fg_clk,
    input  logic             Resetn,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_mode,
    input  logic [31:0]      cfg_init1,
    input  logic [31:0]      cfg_init2,
    input  logic [DIV_W-1:0] rate_div,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      osc_out1,
    output logic             Ready,
    output logic             Enable,
    output logic [2:0]       Mode,
    output logic [31:0]      init1,
    output logic [31:0]      init2,
    output logic             FreqChng,
    output logic             upd_done,
    output logic             busy
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StChgWait,
        StStopWait
    } state_e;

`ifdef SOFT_STOP_EN
    localparam state_e StStopTgt = StStopWait;
`else
    localparam state_e StStopTgt = StIdle;
`endif

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             cfg_loaded_q, cfg_loaded_d;
    logic             freq_chng_q, freq_chng_d;
    logic             upd_done_q, upd_done_d;
`ifdef SOFT_STOP_EN
    logic             pend_q, pend_d;
`endif
    logic             active;
    logic             accept;
    logic             zc;
    logic             unused_osc_bits;

    assign active = (state_q == StRun) || (state_q == StChgWait) || (state_q == StStopWait);
    assign Enable = active && (cnt_q == rate_div);
    // Gated by Resetn so the handshake reads 0 while reset is held.
    assign cfg_ready = Resetn && ((state_q == StIdle) || (state_q == StRun));
    assign accept = cfg_valid && cfg_ready;
    assign Ready = (state_q == StLoad);
    assign busy = (state_q != StIdle);
    assign FreqChng = freq_chng_q;
    assign upd_done = upd_done_q;

    // Same near-zero window the oscillator uses to apply a pending change.
    assign zc = (Mode == 3'd4) ? ((&osc_out1[31:23]) || ~(|osc_out1[31:23]))
                               : ((&osc_out1[31:22]) || ~(|osc_out1[31:22]));
    assign unused_osc_bits = ^osc_out1[21:0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        cfg_loaded_d = cfg_loaded_q | accept;
        freq_chng_d  = 1'b0;
        upd_done_d   = 1'b0;
`ifdef SOFT_STOP_EN
        pend_d       = pend_q;
`endif
        // A count above a freshly lowered rate_div restarts without a tick.
        if (active) begin
            cnt_d = (cnt_q >= rate_div) ? '0 : cnt_q + DIV_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start && cfg_loaded_d) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StRun;
            end
            StRun: begin
                if (stop) begin
                    state_d = StStopTgt;
                end else if (accept) begin
                    state_d     = StChgWait;
                    freq_chng_d = 1'b1;
`ifdef SOFT_STOP_EN
                    pend_d      = 1'b1;
`endif
                end
            end
            StChgWait: begin
                if (stop) begin
                    state_d = StStopTgt;
                end else if (!freq_chng_q && Enable && zc) begin
                    state_d    = StRun;
                    upd_done_d = 1'b1;
`ifdef SOFT_STOP_EN
                    pend_d     = 1'b0;
`endif
                end
            end
`ifdef SOFT_STOP_EN
            StStopWait: begin
                if (Enable && zc) begin
                    state_d    = StIdle;
                    upd_done_d = pend_q;
                    pend_d     = 1'b0;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            cfg_loaded_q <= 1'b0;
            freq_chng_q  <= 1'b0;
            upd_done_q   <= 1'b0;
            Mode         <= '0;
            init1        <= '0;
            init2        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cfg_loaded_q <= cfg_loaded_d;
            freq_chng_q  <= freq_chng_d;
            upd_done_q   <= upd_done_d;
            if (accept) begin
                Mode  <= cfg_mode;
                init1 <= cfg_init1;
                init2 <= cfg_init2;
            end
        end
    end

`ifdef SOFT_STOP_EN
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

endmodule

// File: tb/tb_osc_seq_ctrl.sv
// Bench for osc_seq_ctrl: a phase-level model checked every cycle plus directed scenarios
// with hand-computed expectations. Honours SOFT_STOP_EN when defined.
module tb_osc_seq_ctrl;

    logic        Fg_clk = 1'b0;
    logic        Resetn = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_mode = 3'd0;
    logic [31:0] cfg_init1 = 32'h0;
    logic [31:0] cfg_init2 = 32'h0;
    logic [15:0] rate_div = 16'd3;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] osc_out1 = 32'h1000_0000;
    logic        Ready, Enable, FreqChng, upd_done, busy;
    logic [2:0]  Mode;
    logic [31:0] init1, init2;

    osc_seq_ctrl #(.DIV_W(16)) dut (
        .Fg_clk   (Fg_clk),
        .Resetn   (Resetn),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_mode (cfg_mode),
        .cfg_init1(cfg_init1),
        .cfg_init2(cfg_init2),
        .rate_div (rate_div),
        .start    (start),
        .stop     (stop),
        .osc_out1 (osc_out1),
        .Ready    (Ready),
        .Enable   (Enable),
        .Mode     (Mode),
        .init1    (init1),
        .init2    (init2),
        .FreqChng (FreqChng),
        .upd_done (upd_done),
        .busy     (busy)
    );

    always #5 Fg_clk = ~Fg_clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Near zero means the signed sample lies inside +/-2^23 (mode 4) or +/-2^22 (others).
    function automatic bit zc_of(input logic [2:0] md, input logic [31:0] v);
        int s;
        int lim;
        s = int'(signed'(v));
        lim = (md == 3'd4) ? (1 << 23) : (1 << 22);
        return (s >= -lim) && (s < lim);
    endfunction

`ifdef SOFT_STOP_EN
    localparam bit Soft = 1'b1;
`else
    localparam bit Soft = 1'b0;
`endif

    localparam int PIdle = 0, PLoad = 1, PRun = 2, PChg = 3, PStop = 4;
    int          m_phase = PIdle;
    int          m_tick = 0;
    bit          m_loaded = 0, m_fc = 0, m_upd = 0, m_pend = 0;
    logic [2:0]  m_mode = 3'd0;
    logic [31:0] m_i1 = 32'h0, m_i2 = 32'h0;
    bit          e_cfg_ready, e_enable, m_acc, m_zc;

    always_comb begin
        e_cfg_ready = Resetn && (m_phase == PIdle || m_phase == PRun);
        e_enable    = (m_phase >= PRun) && (m_tick == int'(rate_div));
        m_acc       = cfg_valid && e_cfg_ready;
        m_zc        = zc_of(m_mode, osc_out1);
    end

    always @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            m_phase <= PIdle; m_tick <= 0; m_loaded <= 0; m_fc <= 0; m_upd <= 0; m_pend <= 0;
            m_mode <= 3'd0; m_i1 <= 32'h0; m_i2 <= 32'h0;
        end else begin
            m_fc  <= 0;
            m_upd <= 0;
            if (m_acc) begin
                m_loaded <= 1; m_mode <= cfg_mode; m_i1 <= cfg_init1; m_i2 <= cfg_init2;
            end
            m_tick <= (m_phase >= PRun && m_tick < int'(rate_div)) ? m_tick + 1 : 0;
            case (m_phase)
                PIdle: if (start && (m_loaded || m_acc)) m_phase <= PLoad;
                PLoad: m_phase <= PRun;
                PRun: begin
                    if (stop) m_phase <= Soft ? PStop : PIdle;
                    else if (m_acc) begin
                        m_phase <= PChg; m_fc <= 1; m_pend <= 1;
                    end
                end
                PChg: begin
                    if (stop) begin
                        m_phase <= Soft ? PStop : PIdle;
                        if (!Soft) m_pend <= 0;
                    end else if (!m_fc && e_enable && m_zc) begin
                        m_phase <= PRun; m_upd <= 1; m_pend <= 0;
                    end
                end
                PStop: begin
                    if (e_enable && m_zc) begin
                        m_phase <= PIdle; m_upd <= m_pend; m_pend <= 0;
                    end
                end
                default: m_phase <= PIdle;
            endcase
        end
    end

    always @(negedge Fg_clk) begin
        check("m_busy", 32'(busy), 32'(m_phase != PIdle));
        check("m_ready", 32'(Ready), 32'(m_phase == PLoad));
        check("m_cfg_ready", 32'(cfg_ready), 32'(e_cfg_ready));
        check("m_enable", 32'(Enable), 32'(e_enable));
        check("m_freqchng", 32'(FreqChng), 32'(m_fc));
        check("m_upd_done", 32'(upd_done), 32'(m_upd));
        check("m_mode", 32'(Mode), 32'(m_mode));
        check("m_init1", init1, m_i1);
        check("m_init2", init2, m_i2);
    end

    task automatic tick();
        @(posedge Fg_clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] md, input logic [31:0] i1, input logic [31:0] i2);
        cfg_valid = 1'b1; cfg_mode = md; cfg_init1 = i1; cfg_init2 = i2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_a, n_b, first;
        bit got, prev_en;

        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_cfg_ready", 32'(cfg_ready), 0);
        check("rst_init1", init1, 0);
        #9 Resetn = 1'b1;
        tick();

        // start without any configuration is ignored
        start = 1'b1;
        n_a = 0;
        repeat (5) begin tick(); n_a += int'(busy) + int'(Ready); end
        check("nocfg_busy_ready", n_a, 0);
        start = 1'b0;

        // configure and start in the same cycle
        offer(3'd0, 32'h0100_0000, 32'h3FFF_0000);
        start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        check("load_ready", 32'(Ready), 1);
        check("load_init1", init1, 32'h0100_0000);
        check("load_init2", init2, 32'h3FFF_0000);
        first = -1; n_a = 0; n_b = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (Enable) begin n_a++; if (first < 0) first = k; end
            if (Ready) n_b++;
        end
        check("first_enable", first, 4);
        check("enable_count", n_a, 3);
        check("ready_once", n_b, 0);

        // change request held off until a zero crossing
        offer(3'd0, 32'h0200_0000, 32'h3000_0000);
        tick();
        cfg_valid = 1'b0;
        check("chg_freqchng", 32'(FreqChng), 1);
        check("chg_cfg_ready", 32'(cfg_ready), 0);
        n_a = 0; n_b = 0;
        repeat (50) begin tick(); n_a += int'(upd_done); n_b += int'(FreqChng); end
        check("nozc_upd", n_a, 0);
        check("freqchng_once", n_b, 0);
        osc_out1 = 32'h0010_0000;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            prev_en = Enable;
            tick();
            if (upd_done) begin
                got = 1;
                check("upd_after_enable", 32'(prev_en), 1);
            end
        end
        check("upd_seen", 32'(got), 1);
        check("upd_cfg_ready", 32'(cfg_ready), 1);
        check("upd_busy", 32'(busy), 1);
        tick();
        check("upd_pulse_len", 32'(upd_done), 0);

        // 0x0060_0000 is near zero only under the mode-4 window
        osc_out1 = 32'h0060_0000;
        offer(3'd4, 32'h0300_0000, 32'h2000_0000);
        tick();
        cfg_valid = 1'b0;
        n_a = 0;
        repeat (20) begin tick(); n_a += int'(upd_done); end
        check("mode4_zc_upd", n_a, 1);
        offer(3'd0, 32'h0400_0000, 32'h1000_0000);
        tick();
        cfg_valid = 1'b0;
        n_a = 0;
        repeat (20) begin tick(); n_a += int'(upd_done); end
        check("mode0_nozc_upd", n_a, 0);
        check("mode0_still_wait", 32'(cfg_ready), 0);

        // lowering rate_div below the running count
        rate_div = 16'd10;
        got = 0;
        for (int k = 0; k < 30 && !got; k++) begin tick(); if (Enable) got = 1; end
        check("div10_enable_seen", 32'(got), 1);
        repeat (8) tick();
        rate_div = 16'd2;
        #1;
        check("div_drop_no_enable", 32'(Enable), 0);
        first = -1;
        for (int k = 1; k <= 5 && first < 0; k++) begin tick(); if (Enable) first = k; end
        check("div2_first_enable", first, 3);
        n_a = 0;
        repeat (6) begin tick(); n_a += int'(Enable); end
        check("div2_enable_count", n_a, 2);

        // stop while a change is pending
        stop = 1'b1;
        tick();
        stop = 1'b0;
`ifdef SOFT_STOP_EN
        check("soft_stop_busy", 32'(busy), 1);
        osc_out1 = 32'h0010_0000;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            prev_en = Enable;
            tick();
            if (!busy) begin
                got = 1;
                check("soft_stop_on_enable", 32'(prev_en), 1);
                check("soft_stop_upd", 32'(upd_done), 1);
            end
        end
        check("soft_stop_done", 32'(got), 1);
`else
        check("hard_stop_busy", 32'(busy), 0);
        check("hard_stop_enable", 32'(Enable), 0);
        check("hard_stop_upd", 32'(upd_done), 0);
`endif
        n_a = 0;
        repeat (4) begin tick(); n_a += int'(Enable); end
        check("idle_no_enable", n_a, 0);

        // asynchronous reset in the FreqChng cycle of a change
        rate_div = 16'd3;
        osc_out1 = 32'h1000_0000;
        offer(3'd0, 32'h0100_0000, 32'h3FFF_0000);
        start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        check("rerun_ready", 32'(Ready), 1);
        tick();
        offer(3'd1, 32'h0500_0000, 32'h0600_0000);
        tick();
        cfg_valid = 1'b0;
        check("pre_rst_freqchng", 32'(FreqChng), 1);
        #3 Resetn = 1'b0;
        #1;
        check("arst_outputs", {busy, Ready, Enable, FreqChng, upd_done, cfg_ready, Mode}, 0);
        check("arst_init1", init1, 0);
        check("arst_init2", init2, 0);
        #2 Resetn = 1'b1;
        tick();
        n_a = 0;
        repeat (4) begin tick(); n_a += int'(busy); end
        check("post_rst_idle", n_a, 0);
        start = 1'b1;
        n_a = 0;
        repeat (4) begin tick(); n_a += int'(busy); end
        check("post_rst_nocfg", n_a, 0);
        offer(3'd2, 32'h0700_0000, 32'h0800_0000);
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        check("post_rst_ready", 32'(Ready), 1);
        check("post_rst_mode", 32'(Mode), 2);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
